input_conditioner: RTL

//  Upstream stage of the Processor: cleans the board's raw push-buttons and switches

---
 rtl/input_conditioner.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner
//   Cleans the board's raw push-buttons and switch bank before the core samples
//   them. Both buttons are synchronized and debounced. Each accepted enter
//   press produces a one-cycle enter_pulse and snapshots the switches. Each
//   accepted interruption press sets a sticky int_pending flag.
//
// Ports
//   clock           in   1      divided system clock, rising edge
//   reset           in   1      asynchronous, active-low
//   enter_n         in   1      raw enter button, active-low, asynchronous
//   interruption_n  in   1      raw interruption button, active-low, asynchronous
//   switches        in   WIDTH  raw switch bank, asynchronous
//   int_ack         in   1      core acknowledge; clears int_pending
//   enter_pulse     out  1      one-cycle strobe per accepted enter press
//   switches_data   out  WIDTH  switches captured at the last accepted enter press
//   int_pending     out  1      sticky interrupt request, held until int_ack
//   busy            out  1      either button channel is mid-debounce

// debounce_fsm
//   One button channel. It takes an already synchronized active-low level
//   and emits press_evt for one cycle when a press has been stable long enough.
//
// Ports
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low
//   sync_in    in   1  synchronized button level (0 = pressed)
//   press_evt  out  1  combinational; high in the cycle before the edge that accepts a press
//   busy       out  1  channel is in a debounce state
//
// state  | meaning
// IDLE   | stable released level, waiting for a low sample
// DEB_DN | low seen, counting stable low cycles
// HELD   | press accepted, waiting for a high sample
// DEB_UP | high seen, counting stable high cycles
module debounce_fsm #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic sync_in,
   output logic press_evt,
   output logic busy
);

   typedef enum logic [1:0] {IDLE, DEB_DN, HELD, DEB_UP} state_t;

   // The timer is a down-counter that holds the remaining stable cycles.
   // It is loaded on entry to a debounce state, and the channel moves on
   // at the edge where the count is already zero. That gives exactly
   // DEBOUNCE_CYCLES edges in the debounce state. When DEBOUNCE_CYCLES
   // is 1, the channel still spends one edge there.
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (!sync_in) begin
               state_d = DEB_DN;
               cnt_d   = LOAD;
            end
         end
         DEB_DN: begin
            if (sync_in) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d   = HELD;
               press_evt = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         HELD: begin
            if (sync_in) begin
               state_d = DEB_UP;
               cnt_d   = LOAD;
            end
         end
         DEB_UP: begin
            if (!sync_in) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy = (state_q == DEB_DN) || (state_q == DEB_UP);

endmodule

module input_conditioner #(
   parameter int WIDTH           = 15,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enter_n,
   input  logic             interruption_n,
   input  logic [WIDTH-1:0] switches,
   input  logic             int_ack,
   output logic             enter_pulse,
   output logic [WIDTH-1:0] switches_data,
   output logic             int_pending,
   output logic             busy
);

   logic             enter_meta_q, enter_sync_q;
   logic             intr_meta_q, intr_sync_q;
   logic [WIDTH-1:0] sw_meta_q, sw_sync_q;

   // Button synchronizers reset to the released level. A button that is
   // still held when reset is removed is then seen as a fresh press.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enter_meta_q <= 1'b1;
         enter_sync_q <= 1'b1;
         intr_meta_q  <= 1'b1;
         intr_sync_q  <= 1'b1;
         sw_meta_q    <= '0;
         sw_sync_q    <= '0;
      end else begin
         enter_meta_q <= enter_n;
         enter_sync_q <= enter_meta_q;
         intr_meta_q  <= interruption_n;
         intr_sync_q  <= intr_meta_q;
         sw_meta_q    <= switches;
         sw_sync_q    <= sw_meta_q;
      end
   end

   logic enter_evt, enter_busy;
   logic intr_evt, intr_busy;

   debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_enter_deb (
      .clock    (clock),
      .reset    (reset),
      .sync_in  (enter_sync_q),
      .press_evt(enter_evt),
      .busy     (enter_busy)
   );

   debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_intr_deb (
      .clock    (clock),
      .reset    (reset),
      .sync_in  (intr_sync_q),
      .press_evt(intr_evt),
      .busy     (intr_busy)
   );

   logic             enter_pulse_q, enter_pulse_d;
   logic [WIDTH-1:0] switches_data_q, switches_data_d;
   logic             int_pending_q, int_pending_d;

   always_comb begin
      enter_pulse_d   = enter_evt;
      switches_data_d = enter_evt ? sw_sync_q : switches_data_q;
      // If a new press and int_ack arrive together, the new press wins.
      int_pending_d   = intr_evt | (int_pending_q & ~int_ack);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enter_pulse_q   <= 1'b0;
         switches_data_q <= '0;
         int_pending_q   <= 1'b0;
      end else begin
         enter_pulse_q   <= enter_pulse_d;
         switches_data_q <= switches_data_d;
         int_pending_q   <= int_pending_d;
      end
   end

   assign enter_pulse   = enter_pulse_q;
   assign switches_data = switches_data_q;
   assign int_pending   = int_pending_q;
   assign busy          = enter_busy | intr_busy;

endmodule
